// File: rtl/v_pkg.sv
// Shared types and constants for the vector issue sequencer.
package v_pkg;

  // Datapath unit selected by an instruction.
  typedef enum logic [2:0] {
    U_NONE,
    U_ALU,
    U_MUL,
    U_RED,
    U_SLDU,
    U_LOAD,
    U_STORE,
    U_CFG
  } v_unit_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    CFG,
    ISSUE,
    WAIT,
    WB,
    ERR
  } v_seq_state_e;

  // LSU op codes 1..LSU_LOAD_MAX are loads; above that up to LSU_STORE_MAX are stores.
  localparam logic [3:0] LSU_LOAD_MAX  = 4'd6;
  localparam logic [3:0] LSU_STORE_MAX = 4'd12;

  // Start-bus bit for a unit: {store,load,sldu,red,mul,alu}; CFG and NONE have no start bit.
  function automatic logic [5:0] unit_onehot(input v_unit_e unit);
    logic [5:0] oh;
    oh = 6'b000000;
    case (unit)
      U_ALU:   oh = 6'b000001;
      U_MUL:   oh = 6'b000010;
      U_RED:   oh = 6'b000100;
      U_SLDU:  oh = 6'b001000;
      U_LOAD:  oh = 6'b010000;
      U_STORE: oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/v_unit_classify.sv
// Combinational priority classifier: decoder fields -> destination unit.
module v_unit_classify
  import v_pkg::*;
(
  input  logic [3:0] v_alu_op_i,
  input  logic       is_mul_i,
  input  logic [3:0] v_lsu_op_i,
  input  logic [2:0] v_sldu_op_i,
  input  logic [2:0] v_red_op_i,
  input  logic       is_vconfig_i,
  output logic [2:0] unit_o
);

  v_unit_e unit;

  // Priority cfg > lsu > sldu > red > mul > alu; LSU codes above the store range fall through.
  always_comb begin
    unit = U_NONE;
    if (is_vconfig_i) begin
      unit = U_CFG;
    end else if ((v_lsu_op_i != 4'd0) && (v_lsu_op_i <= LSU_LOAD_MAX)) begin
      unit = U_LOAD;
    end else if ((v_lsu_op_i > LSU_LOAD_MAX) && (v_lsu_op_i <= LSU_STORE_MAX)) begin
      unit = U_STORE;
    end else if (v_sldu_op_i != 3'd0) begin
      unit = U_SLDU;
    end else if (v_red_op_i != 3'd0) begin
      unit = U_RED;
    end else if (is_mul_i) begin
      unit = U_MUL;
    end else if (v_alu_op_i != 4'd0) begin
      unit = U_ALU;
    end
  end

  assign unit_o = unit;

endmodule

// File: rtl/v_issue_seq.sv
// Single-issue vector sequencer: accept, start unit, wait for done, write back.
module v_issue_seq
  import v_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr_in,
  output logic        instr_ready,
  input  logic [3:0]  v_alu_op,
  input  logic        is_mul,
  input  logic [3:0]  v_lsu_op,
  input  logic [2:0]  v_sldu_op,
  input  logic [2:0]  v_red_op,
  input  logic        is_vconfig,
  input  logic        done_valu,
  input  logic        done_vmul,
  input  logic        done_vred,
  input  logic        done_vsldu,
  input  logic        done_vload,
  input  logic        done_store,
  output logic [31:0] instr_q,
  output logic [2:0]  unit_q,
  output logic [5:0]  start,
  output logic        vconfig_wr_en,
  output logic        v_reg_wr_en,
  output logic        x_reg_wr_en,
  output logic        busy,
  output logic        illegal_instr,
  output logic        timeout_err
);

  v_seq_state_e state_q, state_d;
  logic [31:0]  instr_d;
  logic [2:0]   unit_d;
  logic [2:0]   cls_unit;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic         timeout_q, timeout_d;
  logic         illegal_q, illegal_d;
  logic         sel_done;
  v_unit_e      cur_unit;

  v_unit_classify u_classify (
    .v_alu_op_i   (v_alu_op),
    .is_mul_i     (is_mul),
    .v_lsu_op_i   (v_lsu_op),
    .v_sldu_op_i  (v_sldu_op),
    .v_red_op_i   (v_red_op),
    .is_vconfig_i (is_vconfig),
    .unit_o       (cls_unit)
  );

  assign cur_unit      = v_unit_e'(unit_q);
  assign busy          = (state_q != IDLE);
  assign instr_ready   = (state_q == IDLE) && !timeout_q;
  assign illegal_instr = illegal_q;
  assign timeout_err   = timeout_q;

  // Only the latched unit's done is honoured; all others are ignored.
  always_comb begin
    sel_done = 1'b0;
    case (cur_unit)
      U_ALU:   sel_done = done_valu;
      U_MUL:   sel_done = done_vmul;
      U_RED:   sel_done = done_vred;
      U_SLDU:  sel_done = done_vsldu;
      U_LOAD:  sel_done = done_vload;
      U_STORE: sel_done = done_store;
      default: sel_done = 1'b0;
    endcase
  end

  // Next-state, watchdog and Moore pulse outputs.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    unit_d        = unit_q;
    wd_d          = wd_q;
    timeout_d     = timeout_q;
    illegal_d     = 1'b0;
    start         = 6'b000000;
    vconfig_wr_en = 1'b0;
    v_reg_wr_en   = 1'b0;
    x_reg_wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d = instr_in;
          unit_d  = cls_unit;
          if (cls_unit == U_CFG) begin
            state_d = CFG;
          end else if (cls_unit == U_NONE) begin
            illegal_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      CFG: begin
        vconfig_wr_en = 1'b1;
        state_d       = IDLE;
      end
      ISSUE: begin
        start = unit_onehot(cur_unit);
        wd_d  = '0;
        if (sel_done) begin
          state_d = (cur_unit == U_STORE) ? IDLE : WB;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A done arriving on the expiry cycle takes precedence over the error.
        if (sel_done) begin
          state_d = (cur_unit == U_STORE) ? IDLE : WB;
        end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ERR;
        end else if (wd_q != {CNT_W{1'b1}}) begin
          wd_d = wd_q + 1'b1;
        end
      end
      WB: begin
        if (cur_unit == U_RED) begin
          x_reg_wr_en = 1'b1;
        end else begin
          v_reg_wr_en = 1'b1;
        end
        state_d = IDLE;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= 32'd0;
      unit_q    <= U_NONE;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      unit_q    <= unit_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_v_issue_seq.sv
// Scoreboard bench for v_issue_seq: directed plan items plus randomized traffic.
module tb_v_issue_seq;
  import v_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        instr_ready;
  logic [3:0]  v_alu_op;
  logic        is_mul;
  logic [3:0]  v_lsu_op;
  logic [2:0]  v_sldu_op;
  logic [2:0]  v_red_op;
  logic        is_vconfig;
  logic [5:0]  dn;
  logic [31:0] instr_q;
  logic [2:0]  unit_q;
  logic [5:0]  start;
  logic        vconfig_wr_en, v_reg_wr_en, x_reg_wr_en, busy, illegal_instr, timeout_err;

  v_issue_seq #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_in(instr_in), .instr_ready(instr_ready),
    .v_alu_op(v_alu_op), .is_mul(is_mul), .v_lsu_op(v_lsu_op),
    .v_sldu_op(v_sldu_op), .v_red_op(v_red_op), .is_vconfig(is_vconfig),
    .done_valu(dn[0]), .done_vmul(dn[1]), .done_vred(dn[2]),
    .done_vsldu(dn[3]), .done_vload(dn[4]), .done_store(dn[5]),
    .instr_q(instr_q), .unit_q(unit_q), .start(start),
    .vconfig_wr_en(vconfig_wr_en), .v_reg_wr_en(v_reg_wr_en), .x_reg_wr_en(x_reg_wr_en),
    .busy(busy), .illegal_instr(illegal_instr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          cyc;
    logic [5:0]  start;
    logic        cfg;
    logic        vwr;
    logic        xwr;
    logic        ill;
    logic [31:0] instr;
    logic [2:0]  unit;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference classification written directly from the decoder rules.
  function automatic v_unit_e ref_class(input logic [3:0] alu, input logic mul, input logic [3:0] lsu,
                                        input logic [2:0] sldu, input logic [2:0] red, input logic cfg);
    if (cfg) return U_CFG;
    if (lsu >= 1 && lsu <= 6) return U_LOAD;
    if (lsu >= 7 && lsu <= 12) return U_STORE;
    if (sldu != 0) return U_SLDU;
    if (red != 0) return U_RED;
    if (mul) return U_MUL;
    if (alu != 0) return U_ALU;
    return U_NONE;
  endfunction

  function automatic logic [5:0] done_bit(input v_unit_e u);
    case (u)
      U_ALU:   return 6'd1;
      U_MUL:   return 6'd2;
      U_RED:   return 6'd4;
      U_SLDU:  return 6'd8;
      U_LOAD:  return 6'd16;
      U_STORE: return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

  task automatic scramble_fields();
    instr_in   = $urandom;
    v_alu_op   = 4'($urandom);
    is_mul     = 1'($urandom);
    v_lsu_op   = 4'($urandom);
    v_sldu_op  = 3'($urandom);
    v_red_op   = 3'($urandom);
    is_vconfig = 1'($urandom);
  endtask

  task automatic check_reset_vals(input string name);
    chk(name, {instr_q, unit_q, start, vconfig_wr_en, v_reg_wr_en, x_reg_wr_en,
               busy, illegal_instr, timeout_err, instr_ready},
        {32'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  // Monitor: every pulse the DUT shows must match the next scoreboard entry.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (start != 0 || vconfig_wr_en || v_reg_wr_en || x_reg_wr_en || illegal_instr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {start, vconfig_wr_en, v_reg_wr_en, x_reg_wr_en, illegal_instr}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("pulse_kind", {start, vconfig_wr_en, v_reg_wr_en, x_reg_wr_en, illegal_instr},
              {e.start, e.cfg, e.vwr, e.xwr, e.ill});
          chk("instr_q", instr_q, e.instr);
          chk("unit_q", unit_q, e.unit);
        end
      end
    end
  end

  // One transaction; entered and left at a negedge of a cycle in which the DUT is IDLE.
  task automatic run_txn(input logic [3:0] alu, input logic mul, input logic [3:0] lsu,
                         input logic [2:0] sldu, input logic [2:0] red, input logic cfg,
                         input int d, input bit hang);
    v_unit_e    u;
    int         a;
    logic [31:0] w;
    logic [5:0] sel;
    ev_t        e;
    w = $urandom;
    u = ref_class(alu, mul, lsu, sldu, red, cfg);
    sel = done_bit(u);
    instr_valid = 1'b1; instr_in = w;
    v_alu_op = alu; is_mul = mul; v_lsu_op = lsu; v_sldu_op = sldu; v_red_op = red; is_vconfig = cfg;
    a = cyc + 1;
    e.cyc = a; e.start = 6'd0; e.cfg = 1'b0; e.vwr = 1'b0; e.xwr = 1'b0; e.ill = 1'b0;
    e.instr = w; e.unit = u;
    if (u == U_NONE) e.ill = 1'b1;
    else if (u == U_CFG) e.cfg = 1'b1;
    else e.start = sel;
    exp_q.push_back(e);
    if (u != U_NONE && u != U_CFG && u != U_STORE && !hang) begin
      e.cyc = a + d + 1; e.start = 6'd0;
      e.vwr = (u != U_RED); e.xwr = (u == U_RED);
      exp_q.push_back(e);
    end
    @(negedge clk);  // cycle a
    instr_valid = 1'b0;
    scramble_fields();
    if (u == U_CFG) begin
      chk("cfg_busy", {busy, instr_ready}, 2'b10);
      @(negedge clk);
    end else if (u != U_NONE) begin
      for (int t = 0; ; t++) begin
        dn = 6'($urandom) & ~sel;
        if (!hang && t == d) dn = dn | sel;
        chk("wait_busy", {busy, instr_ready}, 2'b10);
        if ((!hang && t == d) || (hang && t == TO)) break;
        @(negedge clk);
      end
      @(negedge clk);
      dn = 6'($urandom) & ~sel;
      if (hang) begin
        chk("timeout_set", {timeout_err, busy, instr_ready}, 3'b110);
        repeat (2) begin
          @(negedge clk);
          chk("err_hold", {timeout_err, busy, instr_ready}, 3'b110);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset_after_err");
      end else if (u != U_STORE) begin
        chk("wb_busy", {busy, instr_ready}, 2'b10);
        @(negedge clk);
      end
    end
    dn = 6'($urandom);
    chk("idle_ready", {busy, instr_ready, timeout_err}, 3'b010);
  endtask

  initial begin
    int gap, d, pick;
    logic [3:0] alu, lsu;
    logic [2:0] sldu, red;
    logic mul, cfg;
    bit hang;
    rst = 1'b1; instr_valid = 1'b0; dn = 6'd0;
    scramble_fields();
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    rst = 1'b0;
    // Directed items from the test plan.
    run_txn(4'd4, 1'b0, 4'd0,  3'd0, 3'd0, 1'b0, 3, 1'b0);  // ALU, done 3 cycles after start
    run_txn(4'd0, 1'b0, 4'd8,  3'd0, 3'd0, 1'b0, 0, 1'b0);  // store, done with start
    run_txn(4'd0, 1'b0, 4'd0,  3'd0, 3'd1, 1'b0, 4, 1'b0);  // reduction with spurious dones
    run_txn(4'd2, 1'b0, 4'd0,  3'd0, 3'd0, 1'b1, 0, 1'b0);  // cfg beats alu
    run_txn(4'd0, 1'b0, 4'd3,  3'd0, 3'd0, 1'b0, 0, 1'b1);  // load timeout
    run_txn(4'd0, 1'b0, 4'd14, 3'd0, 3'd0, 1'b0, 0, 1'b0);  // illegal lsu code
    run_txn(4'd5, 1'b0, 4'd0,  3'd0, 3'd0, 1'b0, 1, 1'b0);  // accepted right after illegal
    run_txn(4'd1, 1'b0, 4'd0,  3'd0, 3'd0, 1'b0, TO, 1'b0); // done on expiry cycle wins
    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        dn = 6'($urandom);
        chk("gap_idle", {busy, instr_ready}, 2'b01);
      end
      pick = $urandom_range(0, 3);
      alu  = (pick == 0) ? 4'($urandom) : 4'd0;
      mul  = ($urandom_range(0, 4) == 0);
      lsu  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      sldu = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
      red  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
      cfg  = ($urandom_range(0, 9) == 0);
      d    = $urandom_range(0, TO);
      hang = ($urandom_range(0, 24) == 0);
      run_txn(alu, mul, lsu, sldu, red, cfg, d, hang);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/v_issue_seq.md
Name: v_issue_seq

Overview:
Single-issue sequencer between the base processor and the vector datapath units: ALU lanes, multiplier, reduction, slide unit, load unit, store unit and the vector CSR.
- Accepts one decoded vector instruction at a time over a valid/ready handshake.
- Latches the instruction and its class, pulses a start to the selected unit, and waits for that unit's done.
- Generates a one-cycle register-file or CSR write enable, then frees itself for the next instruction.
- A watchdog flags a unit that never completes.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before error; legal range 2..1023.
CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
instr_valid  in  1  base processor presents an instruction
instr_in  in  32  raw instruction word
instr_ready  out  1  sequencer can accept (IDLE only)
v_alu_op  in  4  decoder ALU op, 0 = none
is_mul  in  1  decoder multiply flag
v_lsu_op  in  4  decoder LSU op: 1..6 load, 7..12 store, 13..15 illegal
v_sldu_op  in  3  decoder slide op, 0 = none
v_red_op  in  3  decoder reduction op, 0 = none
is_vconfig  in  1  decoder vset* flag
done_valu, done_vmul, done_vred, done_vsldu, done_vload, done_store  in  1 each  unit completion
instr_q  out  32  latched instruction, stable from accept until return to IDLE
unit_q  out  3  latched v_unit_e class
start  out  6  one-hot start pulse {store,load,sldu,red,mul,alu}
vconfig_wr_en  out  1  CSR write pulse
v_reg_wr_en  out  1  vector register writeback pulse
x_reg_wr_en  out  1  scalar writeback pulse (reduction result)
busy  out  1  high in any state except IDLE
illegal_instr  out  1  one-cycle pulse on accept of an unclassifiable instruction
timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset values:
  - All outputs 0 except instr_ready = 1.
  - instr_q = 0, unit_q = U_NONE, state = IDLE, watchdog = 0.
  - rst mid-operation aborts immediately; no pulse is emitted in the reset cycle.
- Classification is combinational on the decoder inputs, with priority cfg > lsu > sldu > red > mul > alu:
  - is_vconfig: U_CFG.
  - v_lsu_op 1..6: U_LOAD.
  - v_lsu_op 7..12: U_STORE.
  - v_sldu_op != 0: U_SLDU.
  - v_red_op != 0: U_RED.
  - is_mul: U_MUL.
  - v_alu_op != 0: U_ALU.
  - Anything else: U_NONE.
- Handshake:
  - Transfer occurs when instr_valid && instr_ready.
  - instr_ready = (state == IDLE) && !timeout_err.
- State IDLE:
  - On transfer, latch instr_q and unit_q.
  - U_CFG: go to CFG.
  - U_NONE: pulse illegal_instr the following cycle and stay in IDLE.
  - Otherwise: go to ISSUE.
- State CFG: vconfig_wr_en = 1 for exactly one cycle, then IDLE. Latency from accept to CSR write is 1 cycle.
- State ISSUE:
  - start[unit] = 1 for exactly one cycle; watchdog cleared.
  - If the selected unit's done is already high this cycle, go to WB (or IDLE for U_STORE). Otherwise go to WAIT.
- State WAIT:
  - Watchdog increments each cycle.
  - Selected done high: go to WB (U_STORE goes to IDLE, no writeback).
  - Watchdog == TIMEOUT_CYCLES-1 with no done: set timeout_err, go to ERR.
  - Done from unselected units is ignored in every state.
- State WB:
  - U_RED: x_reg_wr_en = 1.
  - All other classes: v_reg_wr_en = 1.
  - Exactly one cycle, then IDLE.
  - Minimum accept-to-writeback latency is 2 cycles (done in ISSUE).
- State ERR: busy = 1, instr_ready = 0, no pulses. Exit only via rst.
- Simultaneous done and watchdog expiry in the same WAIT cycle: done wins, no error.
- instr_in and the decoder inputs are ignored outside IDLE. instr_q holds; the decoder may be driven from instr_q.
- The watchdog saturates and never wraps.

Decomposition:
- Shared package v_pkg gains:
  - typedef enum logic [2:0] v_unit_e {U_NONE, U_ALU, U_MUL, U_RED, U_SLDU, U_LOAD, U_STORE, U_CFG}.
  - typedef enum v_seq_state_e {IDLE, CFG, ISSUE, WAIT, WB, ERR}.
  - Constants LSU_LOAD_MAX = 6 and LSU_STORE_MAX = 12.
- One natural sub-module, v_unit_classify: purely combinational priority classifier from the decoder fields to v_unit_e. It is reusable by the writeback mux.

Test Plan:
- ALU op 4, done_valu asserted 3 cycles after start: start = 6'b000001 one cycle after accept; v_reg_wr_en pulse 1 cycle after done; instr_ready back high next cycle.
- Store (v_lsu_op = 8), done_store the same cycle as start: direct ISSUE to IDLE; no v_reg_wr_en or x_reg_wr_en; busy high for exactly 1 cycle.
- Reduction (v_red_op = 1) with spurious done_valu during WAIT, then done_vred: no early exit; x_reg_wr_en pulse only after done_vred.
- is_vconfig with v_alu_op = 2 simultaneously: CFG wins; vconfig_wr_en single pulse; no start bit set.
- Load with no done, TIMEOUT_CYCLES = 8: timeout_err set after 8 WAIT cycles; instr_ready stays 0; rst returns all outputs to reset values.
- v_lsu_op = 14 with all other ops zero: illegal_instr one-cycle pulse; state remains IDLE; next valid ALU instruction accepted the following cycle.
